me_mc_recon: RTL

//   Motion-compensated reconstruction: the decoder-side counterpart of the HEXBS motion estimator.

---
 rtl/me_pkg.sv | 28 ++
 rtl/me_recon_clip.sv | 15 +
 rtl/me_mc_recon.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/me_pkg.sv
// Shared types, widths and the 8-bit saturate helper for the ME / MC blocks.
package me_pkg;

  localparam int unsigned BLK     = 16;
  localparam int unsigned CNT_W   = $clog2(BLK);
  localparam int unsigned MV_W    = 6;
  localparam int unsigned COORD_W = 12;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned RES_W   = 9;
  localparam int unsigned SUM_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Saturate a signed ref+residual sum into the unsigned pixel range.
  function automatic logic [PIX_W-1:0] clip_u8(input logic signed [SUM_W-1:0] s);
    if (s < 0)
      clip_u8 = '0;
    else if (s > 10'sd255)
      clip_u8 = '1;
    else
      clip_u8 = s[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/me_recon_clip.sv
// Combinational reference + residual add with 0..255 saturation.
module me_recon_clip
  import me_pkg::*;
(
  input  logic [PIX_W-1:0] ref_pixel,
  input  logic [RES_W-1:0] res,
  output logic [PIX_W-1:0] pix_c
);

  logic signed [SUM_W-1:0] sum;

  assign sum   = $signed({2'b00, ref_pixel}) + $signed({res[RES_W-1], res});
  assign pix_c = clip_u8(sum);

endmodule

// File: rtl/me_mc_recon.sv
// Motion-compensated reconstruction of one 16x16 block: ref fetch, residual add, clipped raster output.
// Optional ME_MC_REF_CLAMP_EN: clamp reference coordinates into the frame instead of wrapping at 12 bits.
module me_mc_recon
  import me_pkg::*;
#(
  parameter int unsigned ORIGIN = 100
`ifdef ME_MC_REF_CLAMP_EN
  ,
  parameter int unsigned FRAME_W = 640,
  parameter int unsigned FRAME_H = 480
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [MV_W-1:0]    i_mv_x,
  input  logic [MV_W-1:0]    i_mv_y,
  output logic               o_busy,
  output logic [COORD_W-1:0] o_ref_x,
  output logic [COORD_W-1:0] o_ref_y,
  input  logic [PIX_W-1:0]   i_ref_pixel,
  input  logic               i_res_valid,
  input  logic [RES_W-1:0]   i_res_data,
  output logic               o_res_ready,
  output logic               o_pix_valid,
  output logic [PIX_W-1:0]   o_pix_data,
  output logic [CNT_W-1:0]   o_pix_x,
  output logic [CNT_W-1:0]   o_pix_y,
  input  logic               i_pix_ready,
  output logic               o_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLK - 1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt_x, cnt_x_nxt, cnt_y, cnt_y_nxt;
  logic [MV_W-1:0]    mv_x, mv_x_nxt, mv_y, mv_y_nxt;
  logic               pix_valid_nxt, busy_nxt, done_nxt;
  logic [PIX_W-1:0]   pix_data_nxt, recon_c;
  logic [CNT_W-1:0]   pix_x_nxt, pix_y_nxt;
  logic               accept_c, handoff_c, last_c;

  assign handoff_c   = o_pix_valid && i_pix_ready;
  assign o_res_ready = (state == ST_RUN) && (!o_pix_valid || i_pix_ready);
  assign accept_c    = o_res_ready && i_res_valid;
  assign last_c      = (cnt_x == CNT_MAX) && (cnt_y == CNT_MAX);

`ifdef ME_MC_REF_CLAMP_EN
  // One extra bit so negative coordinates are visible and can clamp to the frame edge.
  localparam int unsigned EXT_W = COORD_W + 1;
  logic [EXT_W-1:0] ext_x, ext_y;

  assign ext_x = EXT_W'(ORIGIN) + {{(EXT_W-MV_W){mv_x[MV_W-1]}}, mv_x} + EXT_W'(cnt_x);
  assign ext_y = EXT_W'(ORIGIN) + {{(EXT_W-MV_W){mv_y[MV_W-1]}}, mv_y} + EXT_W'(cnt_y);
  assign o_ref_x = ext_x[EXT_W-1] ? '0 :
                   (ext_x > EXT_W'(FRAME_W - 1)) ? COORD_W'(FRAME_W - 1) : ext_x[COORD_W-1:0];
  assign o_ref_y = ext_y[EXT_W-1] ? '0 :
                   (ext_y > EXT_W'(FRAME_H - 1)) ? COORD_W'(FRAME_H - 1) : ext_y[COORD_W-1:0];
`else
  assign o_ref_x = COORD_W'(ORIGIN) + {{(COORD_W-MV_W){mv_x[MV_W-1]}}, mv_x} + COORD_W'(cnt_x);
  assign o_ref_y = COORD_W'(ORIGIN) + {{(COORD_W-MV_W){mv_y[MV_W-1]}}, mv_y} + COORD_W'(cnt_y);
`endif

  me_recon_clip u_clip (
    .ref_pixel (i_ref_pixel),
    .res       (i_res_data),
    .pix_c     (recon_c)
  );

  // Next-state, counter and output-register logic.
  always_comb begin
    state_nxt     = state;
    cnt_x_nxt     = cnt_x;
    cnt_y_nxt     = cnt_y;
    mv_x_nxt      = mv_x;
    mv_y_nxt      = mv_y;
    pix_valid_nxt = o_pix_valid;
    pix_data_nxt  = o_pix_data;
    pix_x_nxt     = o_pix_x;
    pix_y_nxt     = o_pix_y;
    done_nxt      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = ST_RUN;
          mv_x_nxt  = i_mv_x;
          mv_y_nxt  = i_mv_y;
          cnt_x_nxt = '0;
          cnt_y_nxt = '0;
        end
      end
      ST_RUN: begin
        if (accept_c && last_c) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (handoff_c) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (handoff_c) pix_valid_nxt = 1'b0;

    // A new accept overrides the handoff clear, so back-to-back pixels have no bubble.
    if (accept_c) begin
      pix_valid_nxt = 1'b1;
      pix_data_nxt  = recon_c;
      pix_x_nxt     = cnt_x;
      pix_y_nxt     = cnt_y;
      if (cnt_x == CNT_MAX) begin
        cnt_x_nxt = '0;
        cnt_y_nxt = (cnt_y == CNT_MAX) ? '0 : cnt_y + CNT_W'(1);
      end else begin
        cnt_x_nxt = cnt_x + CNT_W'(1);
      end
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt_x       <= '0;
      cnt_y       <= '0;
      mv_x        <= '0;
      mv_y        <= '0;
      o_busy      <= 1'b0;
      o_pix_valid <= 1'b0;
      o_pix_data  <= '0;
      o_pix_x     <= '0;
      o_pix_y     <= '0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt_x       <= cnt_x_nxt;
      cnt_y       <= cnt_y_nxt;
      mv_x        <= mv_x_nxt;
      mv_y        <= mv_y_nxt;
      o_busy      <= busy_nxt;
      o_pix_valid <= pix_valid_nxt;
      o_pix_data  <= pix_data_nxt;
      o_pix_x     <= pix_x_nxt;
      o_pix_y     <= pix_y_nxt;
      o_done      <= done_nxt;
    end
  end

endmodule
